// File: rtl/pipe_stage_regs.sv
// PC, IF/ID, ID/EX-control and EX/MEM-control registers driven by hazard-unit requests,
// with a RUN/STALL/HALT front-end state machine. Define PIPE_PERF_CNT_EN to add stall/flush counters.
module pipe_stage_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned CTRL_W    = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              IF_ID_FLUSH,
  input  logic              ID_EX_sel,
  input  logic              EX_MEM_sel,
  input  logic              PCSrc,
  input  logic [31:0]       branch_target,
  input  logic              brk,
  input  logic              resume,
  input  logic [31:0]       if_instr,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [CTRL_W-1:0] ex_ctrl,
  output logic [31:0]       pc,
  output logic [31:0]       IF_ID_instr,
  output logic [31:0]       IF_ID_PC4,
  output logic              IF_ID_valid,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
  output logic [CTRL_W-1:0] EX_MEM_ctrl,
  output logic              halted,
  output logic              stalled
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        pc4_q, pc4_d;
  logic               valid_q, valid_d;
  logic [CTRL_W-1:0]  idex_q, idex_d;
  logic [CTRL_W-1:0]  exmem_q, exmem_d;
  logic               halted_q, stalled_q;
  logic [31:0]        pc_plus4;
  logic               stall_cond;

  assign pc_plus4   = pc_q + 32'd4;
  assign stall_cond = !PCWrite && !IF_ID_Write && !PCSrc && !brk;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    idex_d  = idex_q;
    exmem_d = exmem_q;
    case (state_q)
      HALT: begin
        // Frozen front end; resume only re-enables updates from the next edge on.
        valid_d = 1'b0;
        idex_d  = '0;
        exmem_d = '0;
        if (resume) state_d = RUN;
      end
      default: begin
        if (brk) begin
          state_d = HALT;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          idex_d  = '0;
          exmem_d = '0;
        end else begin
          if (PCSrc)        pc_d = branch_target;
          else if (PCWrite) pc_d = pc_plus4;
          if (IF_ID_FLUSH) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end else if (IF_ID_Write) begin
            instr_d = if_instr;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
          idex_d  = ID_EX_sel  ? '0 : id_ctrl;
          exmem_d = EX_MEM_sel ? '0 : ex_ctrl;
          state_d = stall_cond ? STALL : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc4_q     <= '0;
      valid_q   <= 1'b0;
      idex_q    <= '0;
      exmem_q   <= '0;
      halted_q  <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d;
      idex_q    <= idex_d;
      exmem_q   <= exmem_d;
      halted_q  <= (state_d == HALT);
      stalled_q <= (state_d == STALL);
    end
  end

  assign pc          = pc_q;
  assign IF_ID_instr = instr_q;
  assign IF_ID_PC4   = pc4_q;
  assign IF_ID_valid = valid_q;
  assign ID_EX_ctrl  = idex_q;
  assign EX_MEM_ctrl = exmem_q;
  assign halted      = halted_q;
  assign stalled     = stalled_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_q == STALL && stall_cnt_q != '1)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (IF_ID_FLUSH && state_q != HALT && flush_cnt_q != '1)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed self-checking bench for pipe_stage_regs (optionally with PIPE_PERF_CNT_EN counters).
module tb_pipe_stage_regs;
  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          rst_n, PCWrite, IF_ID_Write, IF_ID_FLUSH, ID_EX_sel, EX_MEM_sel;
  logic          PCSrc, brk, resume;
  logic [31:0]   branch_target, if_instr;
  logic [CW-1:0] id_ctrl, ex_ctrl;
  logic [31:0]   pc, IF_ID_instr, IF_ID_PC4;
  logic          IF_ID_valid, halted, stalled;
  logic [CW-1:0] ID_EX_ctrl, EX_MEM_ctrl;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_regs #(.RESET_PC(32'h0), .CTRL_W(CW), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_sel(ID_EX_sel), .EX_MEM_sel(EX_MEM_sel),
    .PCSrc(PCSrc), .branch_target(branch_target), .brk(brk), .resume(resume),
    .if_instr(if_instr), .id_ctrl(id_ctrl), .ex_ctrl(ex_ctrl), .pc(pc),
    .IF_ID_instr(IF_ID_instr), .IF_ID_PC4(IF_ID_PC4), .IF_ID_valid(IF_ID_valid),
    .ID_EX_ctrl(ID_EX_ctrl), .EX_MEM_ctrl(EX_MEM_ctrl), .halted(halted), .stalled(stalled)
`ifdef PIPE_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_ID_FLUSH = 1'b0;
    ID_EX_sel = 1'b0; EX_MEM_sel = 1'b0; PCSrc = 1'b0; brk = 1'b0; resume = 1'b0;
    branch_target = 32'h0; if_instr = 32'h0; id_ctrl = '0; ex_ctrl = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      {PCWrite, IF_ID_Write, IF_ID_FLUSH, ID_EX_sel, EX_MEM_sel, PCSrc, brk, resume} = 8'($urandom);
      branch_target = $urandom; if_instr = $urandom;
      id_ctrl = CW'($urandom); ex_ctrl = CW'($urandom);
      tick();
    end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    checks++; if (IF_ID_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected %h", IF_ID_instr, 32'h0); end
    checks++; if (IF_ID_PC4 !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h expected %h", IF_ID_PC4, 32'h0); end
    checks++; if (IF_ID_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", IF_ID_valid); end
    checks++; if (ID_EX_ctrl !== '0 || EX_MEM_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl: got %h/%h expected 0/0", ID_EX_ctrl, EX_MEM_ctrl); end
    checks++; if (halted !== 1'b0 || stalled !== 1'b0) begin errors++; $display("FAIL reset_state: got halted=%b stalled=%b expected 0/0", halted, stalled); end
  endtask

  task automatic test_load_use_stall();
    idle_inputs();
    id_ctrl = 10'h155; ex_ctrl = 10'h2AA;
    for (int i = 0; i < 4; i++) begin
      if_instr = 32'h1000 + 32'(i);
      tick();
    end
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL run_pc: got %h expected %h", pc, 32'h10); end
    checks++; if (IF_ID_instr !== 32'h1003 || IF_ID_PC4 !== 32'h10 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL run_ifid: got %h/%h/%b expected 1003/10/1", IF_ID_instr, IF_ID_PC4, IF_ID_valid); end
    checks++; if (ID_EX_ctrl !== 10'h155 || EX_MEM_ctrl !== 10'h2AA) begin errors++; $display("FAIL run_ctrl: got %h/%h expected 155/2aa", ID_EX_ctrl, EX_MEM_ctrl); end
    PCWrite = 1'b0; IF_ID_Write = 1'b0; ID_EX_sel = 1'b1; if_instr = 32'hDEAD;
    tick();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pc: got %h expected %h", pc, 32'h10); end
    checks++; if (IF_ID_instr !== 32'h1003 || IF_ID_PC4 !== 32'h10 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid: got %h/%h/%b expected 1003/10/1", IF_ID_instr, IF_ID_PC4, IF_ID_valid); end
    checks++; if (ID_EX_ctrl !== '0) begin errors++; $display("FAIL stall_idex: got %h expected 0", ID_EX_ctrl); end
    checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_flag: got %b expected 1", stalled); end
    PCWrite = 1'b1; IF_ID_Write = 1'b1; ID_EX_sel = 1'b0; if_instr = 32'h2004;
    tick();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL unstall_pc: got %h expected %h", pc, 32'h14); end
    checks++; if (IF_ID_instr !== 32'h2004 || IF_ID_PC4 !== 32'h14) begin errors++; $display("FAIL unstall_ifid: got %h/%h expected 2004/14", IF_ID_instr, IF_ID_PC4); end
    checks++; if (stalled !== 1'b0 || ID_EX_ctrl !== 10'h155) begin errors++; $display("FAIL unstall_state: got stalled=%b idex=%h expected 0/155", stalled, ID_EX_ctrl); end
  endtask

  task automatic test_branch();
    idle_inputs();
    id_ctrl = 10'h155; ex_ctrl = 10'h2AA; if_instr = 32'hBEEF;
    PCSrc = 1'b1; branch_target = 32'h40; IF_ID_FLUSH = 1'b1; ID_EX_sel = 1'b1; EX_MEM_sel = 1'b1; PCWrite = 1'b0;
    tick();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL branch_pc: got %h expected %h", pc, 32'h40); end
    checks++; if (IF_ID_instr !== 32'h0 || IF_ID_valid !== 1'b0 || IF_ID_PC4 !== 32'h14) begin errors++; $display("FAIL branch_ifid: got %h/%b/%h expected 0/0/14", IF_ID_instr, IF_ID_valid, IF_ID_PC4); end
    checks++; if (ID_EX_ctrl !== '0 || EX_MEM_ctrl !== '0) begin errors++; $display("FAIL branch_ctrl: got %h/%h expected 0/0", ID_EX_ctrl, EX_MEM_ctrl); end
    checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL branch_stall: got %b expected 0", stalled); end
  endtask

  task automatic test_break_resume();
    idle_inputs();
    PCSrc = 1'b1; branch_target = 32'h20; if_instr = 32'h7777;
    tick();
    checks++; if (pc !== 32'h20) begin errors++; $display("FAIL brk_setup_pc: got %h expected %h", pc, 32'h20); end
    PCSrc = 1'b0; brk = 1'b1; id_ctrl = 10'h0F0; ex_ctrl = 10'h00F; if_instr = 32'h8888;
    tick();
    checks++; if (halted !== 1'b1 || pc !== 32'h20) begin errors++; $display("FAIL brk_enter: got halted=%b pc=%h expected 1/20", halted, pc); end
    checks++; if (IF_ID_instr !== 32'h0 || IF_ID_valid !== 1'b0 || ID_EX_ctrl !== '0 || EX_MEM_ctrl !== '0) begin errors++; $display("FAIL brk_flush: got %h/%b/%h/%h expected 0/0/0/0", IF_ID_instr, IF_ID_valid, ID_EX_ctrl, EX_MEM_ctrl); end
    brk = 1'b0; PCSrc = 1'b1; branch_target = 32'h300;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (pc !== 32'h20 || halted !== 1'b1 || IF_ID_valid !== 1'b0 || ID_EX_ctrl !== '0) begin errors++; $display("FAIL halt_hold: got pc=%h halted=%b valid=%b idex=%h expected 20/1/0/0", pc, halted, IF_ID_valid, ID_EX_ctrl); end
    end
    PCSrc = 1'b0; resume = 1'b1; if_instr = 32'h9999;
    tick();
    checks++; if (halted !== 1'b0 || pc !== 32'h20 || IF_ID_valid !== 1'b0) begin errors++; $display("FAIL resume_edge: got halted=%b pc=%h valid=%b expected 0/20/0", halted, pc, IF_ID_valid); end
    resume = 1'b0;
    tick();
    checks++; if (pc !== 32'h24 || IF_ID_instr !== 32'h9999 || IF_ID_PC4 !== 32'h24 || IF_ID_valid !== 1'b1) begin errors++; $display("FAIL resume_fetch: got %h/%h/%h/%b expected 24/9999/24/1", pc, IF_ID_instr, IF_ID_PC4, IF_ID_valid); end
  endtask

  task automatic test_wrap_priority();
    idle_inputs();
    PCSrc = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    PCSrc = 1'b0;
    tick();
    checks++; if (pc !== 32'h0 || IF_ID_PC4 !== 32'h0) begin errors++; $display("FAIL wrap_pc: got pc=%h pc4=%h expected 0/0", pc, IF_ID_PC4); end
    PCSrc = 1'b1; branch_target = 32'h80; brk = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL brk_vs_branch: got halted=%b pc=%h expected 1/0", halted, pc); end
    PCSrc = 1'b0; resume = 1'b1;
    tick();
    checks++; if (halted !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL resume_wins: got halted=%b pc=%h expected 0/0", halted, pc); end
    brk = 1'b0; resume = 1'b0; PCSrc = 1'b1; branch_target = 32'h80;
    tick();
    PCSrc = 1'b0; brk = 1'b1;
    tick();
    checks++; if (halted !== 1'b1 || pc !== 32'h80) begin errors++; $display("FAIL halt_before_rst: got halted=%b pc=%h expected 1/80", halted, pc); end
    brk = 1'b0; rst_n = 1'b0; PCSrc = 1'b1; branch_target = 32'h500;
    tick();
    checks++; if (halted !== 1'b0 || pc !== 32'h0 || IF_ID_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_halt: got halted=%b pc=%h valid=%b expected 0/0/0", halted, pc, IF_ID_valid); end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_perf_cnt();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++; if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin errors++; $display("FAIL cnt_reset: got %0d/%0d expected 0/0", stall_cnt, flush_cnt); end
    rst_n = 1'b1; PCWrite = 1'b0; IF_ID_Write = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    PCWrite = 1'b1; IF_ID_Write = 1'b1;
    tick();
    checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_cnt: got %0d expected 3", stall_cnt); end
    IF_ID_FLUSH = 1'b1;
    for (int i = 0; i < 2; i++) tick();
    IF_ID_FLUSH = 1'b0; brk = 1'b1;
    tick();
    brk = 1'b0; IF_ID_FLUSH = 1'b1;
    tick();
    checks++; if (flush_cnt !== 32'd2 || stall_cnt !== 32'd3) begin errors++; $display("FAIL flush_cnt: got flush=%0d stall=%0d expected 2/3", flush_cnt, stall_cnt); end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_load_use_stall();
    test_branch();
    test_break_resume();
    test_wrap_priority();
`ifdef PIPE_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
